fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the RV32 core. Owns the program counter and issues in-order fetch requests to instruction memory over a valid/ready interface.
- Tracks in-flight fetches in a small in-order buffer and applies redirects and traps using an epoch bit, so stale responses are dropped.
- Presents fetched instructions to decode with a stall-aware valid signal, and supports halt/drain.

---
 rtl/fetch_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the RV32 core.
// Owns the PC, issues in-order fetches to instruction memory, tracks
// in-flight fetches in a DEPTH-entry in-order buffer tagged with an epoch
// bit, and presents completed instructions to decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect
// targets trap to TRAP_VEC and pulse misalign_err).
//
// Handshake: a request transfers on a cycle where imem_req_valid &&
// imem_req_ready; once raised, valid and addr hold until accepted unless a
// redirect, trap or halt withdraws the request. Responses arrive in order,
// one per imem_rsp_valid cycle. Decode takes an instruction on a cycle where
// if_valid && !stall.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_valid,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        halted,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic [1:0]  dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   pc;
    logic          epoch;

    // In-flight buffer: allocated at tail on accept, filled in order at
    // fill_ptr on response, retired from head.
    logic [31:0]   ent_pc    [DEPTH];
    logic [31:0]   ent_instr [DEPTH];
    logic          ent_epoch [DEPTH];
    logic          ent_done  [DEPTH];
    logic [AW-1:0] head, tail, fill_ptr;
    logic [CW-1:0] cnt;   // allocated entries
    logic [CW-1:0] pend;  // allocated entries still awaiting a response

    logic          misalign;
    logic          flush;
    logic          take_trap;
    logic [31:0]   flush_pc;
    logic          free_slot;
    logic          accept;
    logic          fill;
    logic          head_done;
    logic          head_cur;
    logic          pop;

    // Redirect/trap decode: any flush toggles the epoch; trap wins over redirect.
    always_comb begin
        misalign  = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif
        flush     = redirect_valid || trap_valid;
        take_trap = trap_valid || misalign;
        flush_pc  = take_trap ? TRAP_VEC : {redirect_pc[31:2], 2'b00};
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_err = !reset && misalign;
`endif

    // Request, fill and retirement qualifiers.
    always_comb begin
        free_slot      = (cnt != CW'(DEPTH));
        imem_req_valid = !reset && (state == S_RUN) && free_slot && !flush;
        imem_req_addr  = pc;
        accept         = imem_req_valid && imem_req_ready;
        fill           = !reset && imem_rsp_valid && (pend != '0);
        head_done      = (cnt != '0) && ent_done[head];
        head_cur       = (ent_epoch[head] == epoch);
        if_valid       = !reset && head_done && head_cur && !flush;
        if_pc          = ent_pc[head];
        if_instr       = ent_instr[head];
        // Stale heads leave silently even under stall; current ones need decode.
        pop            = !reset && head_done && (!head_cur || (if_valid && !stall));
        halted         = !reset && (state == S_HALTED);
        dbg_state      = state;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_BOOT;
        else       state <= state_nxt;
    end

    // FSM next-state: boot cycle, run, drain outstanding responses, halt.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:   state_nxt = S_RUN;
            S_RUN:    if (halt_req) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (!halt_req)          state_nxt = S_RUN;
                else if (pend == '0)    state_nxt = S_HALTED;
            end
            S_HALTED: if (!halt_req) state_nxt = S_RUN;
            default:  state_nxt = S_BOOT;
        endcase
    end

    // PC, epoch, pointers and occupancy counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            epoch    <= 1'b0;
            head     <= '0;
            tail     <= '0;
            fill_ptr <= '0;
            cnt      <= '0;
            pend     <= '0;
        end else begin
            if (flush) begin
                pc    <= flush_pc;
                epoch <= ~epoch;
            end else if (accept) begin
                pc    <= pc + 32'd4;
            end
            if (accept) tail     <= tail + AW'(1);
            if (fill)   fill_ptr <= fill_ptr + AW'(1);
            if (pop)    head     <= head + AW'(1);
            cnt  <= cnt  + CW'(accept) - CW'(pop);
            pend <= pend + CW'(accept) - CW'(fill);
        end
    end

    // Per-entry done flags: cleared on allocation, set by the in-order fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_done[i] <= 1'b0;
        end else begin
            if (accept) ent_done[tail]     <= 1'b0;
            if (fill)   ent_done[fill_ptr] <= 1'b1;
        end
    end

    // Entry payload: address/epoch captured on accept, instruction on fill.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_pc[tail]    <= pc;
            ent_epoch[tail] <= epoch;
        end
        if (fill) ent_instr[fill_ptr] <= imem_rsp_data;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with an in-order memory
// model and a scoreboard of expected {pc, instr} pairs.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        halted;
    logic [1:0]  dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int          checks = 0;
    int          failures = 0;
    int          retired = 0;
    logic [31:0] last_ret_pc = '0;
    logic [31:0] exp_addr = RESET_PC;
    logic        rsp_en = 1'b1;
    logic [31:0] mq[$];
    logic [63:0] exp_q[$];

    fetch_ctrl #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .halted(halted),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_err(misalign_err),
`endif
        .dbg_state(dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1234_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ret(input int target);
        for (int k = 0; k < 200 && retired < target; k++) step();
        check("wait_retire", 32'(retired >= target), 32'd1);
    endtask

    task automatic wait_mq(input int n);
        for (int k = 0; k < 100 && mq.size() != n; k++) step();
        check("wait_inflight", 32'(mq.size()), 32'(n));
    endtask

    // Memory model: checks each accepted address against the PC model,
    // records the expected retirement, and returns responses in order
    // one cycle after acceptance while rsp_en is set.
    always @(posedge clk) begin
        logic        acc_now;
        logic [31:0] a_now;
        logic        rv;
        logic [31:0] rd;
        acc_now = imem_req_valid && imem_req_ready && !reset;
        a_now   = imem_req_addr;
        rv = 1'b0;
        rd = '0;
        if (reset) begin
            mq.delete();
        end else begin
            if (acc_now) begin
                check("req_addr", a_now, exp_addr);
                exp_addr = exp_addr + 32'd4;
                mq.push_back(a_now);
                exp_q.push_back({a_now, instr_of(a_now)});
            end
            if (rsp_en && mq.size() > 0) begin
                rv = 1'b1;
                rd = instr_of(mq.pop_front());
            end
        end
        #1;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
    end

    // Scoreboard: every instruction taken by decode must match the oldest expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!reset && if_valid === 1'b1 && stall === 1'b0) begin
            check("if_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("if_pc", if_pc, e[63:32]);
                check("if_instr", if_instr, e[31:0]);
            end
            retired++;
            last_ret_pc = if_pc;
        end
    end

    initial begin
        int          r0;
        logic [63:0] held;

        // Reset state.
        repeat (3) begin
            step();
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_if_valid", 32'(if_valid), 32'd0);
            check("rst_halted", 32'(halted), 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
            check("rst_misalign", 32'(misalign_err), 32'd0);
`endif
        end
        reset = 1'b0;
        #1;
        check("boot_no_req", 32'(imem_req_valid), 32'd0);
        step();
        check("run_req_valid", 32'(imem_req_valid), 32'd1);
        check("run_req_addr", imem_req_addr, RESET_PC);

        // Streaming fetch.
        wait_ret(6);

        // Memory back-pressure: address holds until accepted.
        imem_req_ready = 1'b0;
        repeat (4) step();
        repeat (3) begin
            check("bp_req_valid", 32'(imem_req_valid), 32'd1);
            check("bp_req_addr", imem_req_addr, exp_addr);
            step();
        end
        imem_req_ready = 1'b1;

        // In-flight limit: with responses withheld only DEPTH requests go out.
        rsp_en = 1'b0;
        repeat (6) step();
        check("depth_inflight", 32'(mq.size()), 32'd2);
        check("depth_no_req", 32'(imem_req_valid), 32'd0);
        rsp_en = 1'b1;
        wait_ret(retired + 4);

        // Decode stall holds the presented instruction.
        stall = 1'b1;
        for (int k = 0; k < 20 && if_valid !== 1'b1; k++) step();
        check("stall_valid0", 32'(if_valid), 32'd1);
        held = (exp_q.size() != 0) ? exp_q[0] : 64'd0;
        check("stall_pc0", if_pc, held[63:32]);
        repeat (4) begin
            step();
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_pc", if_pc, held[63:32]);
            check("stall_instr", if_instr, held[31:0]);
        end
        check("stall_full_no_req", 32'(imem_req_valid), 32'd0);
        stall = 1'b0;
        wait_ret(retired + 3);

        // Redirect with two fetches in flight: both responses dropped.
        rsp_en = 1'b0;
        wait_mq(2);
        r0 = retired;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        exp_addr       = 32'h0000_0200;
        exp_q.delete();
        #1;
        check("redir_if_valid", 32'(if_valid), 32'd0);
        check("redir_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        redirect_valid = 1'b0;
        rsp_en = 1'b1;
        wait_ret(r0 + 1);
        check("redir_first_pc", last_ret_pc, 32'h0000_0200);
        wait_ret(r0 + 3);

        // Trap and redirect together: trap vector wins.
        r0 = retired;
        trap_valid     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        exp_addr       = TRAP_VEC;
        exp_q.delete();
        #1;
        check("trap_req_valid", 32'(imem_req_valid), 32'd0);
        step();
        trap_valid     = 1'b0;
        redirect_valid = 1'b0;
        wait_ret(r0 + 1);
        check("trap_first_pc", last_ret_pc, TRAP_VEC);
        wait_ret(r0 + 3);

        // Halt with two in flight: drain, halt, resume at next pc.
        rsp_en = 1'b0;
        wait_mq(2);
        r0 = retired;
        halt_req = 1'b1;
        step();
        repeat (2) begin
            check("drain_no_req", 32'(imem_req_valid), 32'd0);
            check("drain_not_halted", 32'(halted), 32'd0);
            step();
        end
        rsp_en = 1'b1;
        for (int k = 0; k < 20 && halted !== 1'b1; k++) step();
        check("halted", 32'(halted), 32'd1);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
        check("halt_retired", 32'(retired - r0), 32'd2);
        check("halt_no_req", 32'(imem_req_valid), 32'd0);
        halt_req = 1'b0;
        step();
        check("resume_not_halted", 32'(halted), 32'd0);
        wait_ret(r0 + 4);

        // Misaligned redirect target.
        r0 = retired;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
        exp_addr = TRAP_VEC;
        #1;
        check("misalign_pulse", 32'(misalign_err), 32'd1);
`else
        exp_addr = 32'h0000_0200;
`endif
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        #1;
        check("misalign_clear", 32'(misalign_err), 32'd0);
`endif
        wait_ret(r0 + 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign_pc", last_ret_pc, TRAP_VEC);
`else
        check("misalign_pc", last_ret_pc, 32'h0000_0200);
`endif

        // Reset mid-operation: back to reset values and refetch from RESET_PC.
        repeat (2) step();
        reset = 1'b1;
        exp_q.delete();
        exp_addr = RESET_PC;
        step();
        step();
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("mid_rst_if_valid", 32'(if_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_boot_no_req", 32'(imem_req_valid), 32'd0);
        r0 = retired;
        wait_ret(r0 + 1);
        check("mid_rst_first_pc", last_ret_pc, RESET_PC);
        wait_ret(r0 + 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
